// File: rtl/on_taraf_tampon.sv
// rtl/on_taraf_tampon.sv - credit-based prefetch FIFO fetch front end feeding GC.
// Optional ON_TARAF_SAYAC_EN adds redirect and empty-cycle counters.
module on_taraf_tampon #(
    parameter int                     ADRES_BIT        = 32,
    parameter int                     BUYRUK_BIT       = 32,
    parameter int                     DERINLIK         = 4,
    parameter logic [ADRES_BIT-1:0]   BASLANGIC_ADRESI = 32'h4000_0000,
    parameter logic [ADRES_BIT-1:0]   BASBEL_TABAN_ADR = 32'h4000_0000,
    parameter logic [ADRES_BIT-1:0]   BB_TABAN_ADR     = 32'h4000_1000
) (
    input  logic                          clk_g,
    input  logic                          rst_n_g,
    input  logic                          gc_hazir_g,
    output logic                          bb_buy_gecerli_c,
    output logic [BUYRUK_BIT-1:0]         bb_buy_c,
    output logic [ADRES_BIT-1:0]          bb_buy_ps_c,
    input  logic                          bb_buy_istek_g,
    input  logic [ADRES_BIT-1:0]          bb_buy_istek_adres_g,
    output logic [ADRES_BIT-1:0]          bb_addra_c,
    output logic                          bb_ena_c,
    input  logic [BUYRUK_BIT-1:0]         bb_douta_g,
    output logic [ADRES_BIT-1:0]          basbel_addra_c,
    output logic                          basbel_ena_c,
    input  logic [BUYRUK_BIT-1:0]         basbel_douta_g,
    output logic [$clog2(DERINLIK):0]     tampon_doluluk_c
`ifdef ON_TARAF_SAYAC_EN
    ,
    output logic [31:0]                   yonlendirme_sayisi_c,
    output logic [31:0]                   bos_bekleme_sayisi_c
`endif
);

    localparam int PW = $clog2(DERINLIK);
    localparam int CW = PW + 1;
    localparam logic [CW:0] KAPASITE = (CW+1)'(DERINLIK);

    logic [ADRES_BIT-1:0]  getir_ps_q, getir_ps_d;
    logic                  ucusta_q, ucusta_d;
    logic [ADRES_BIT-1:0]  istek_ps_q, istek_ps_d;
    logic                  istek_basbel_q, istek_basbel_d;
    logic [PW-1:0]         yaz_ptr_q, yaz_ptr_d;
    logic [PW-1:0]         oku_ptr_q, oku_ptr_d;
    logic [CW-1:0]         doluluk_q, doluluk_d;
    logic [BUYRUK_BIT-1:0] buy_mem_q [DERINLIK];
    logic [BUYRUK_BIT-1:0] buy_mem_d [DERINLIK];
    logic [ADRES_BIT-1:0]  ps_mem_q  [DERINLIK];
    logic [ADRES_BIT-1:0]  ps_mem_d  [DERINLIK];

    logic                  gecerli;
    logic                  kaynak_basbel;
    logic                  kredi_var;
    logic                  cek;
    logic                  yaz;
    logic                  oku;
    logic [BUYRUK_BIT-1:0] gelen_buy;

    always_comb begin
        getir_ps_d     = getir_ps_q;
        ucusta_d       = 1'b0;
        istek_ps_d     = istek_ps_q;
        istek_basbel_d = istek_basbel_q;
        yaz_ptr_d      = yaz_ptr_q;
        oku_ptr_d      = oku_ptr_q;
        doluluk_d      = doluluk_q;
        buy_mem_d      = buy_mem_q;
        ps_mem_d       = ps_mem_q;

        gecerli       = (doluluk_q != '0);
        kaynak_basbel = (getir_ps_q < BB_TABAN_ADR);
        // Credits: registered occupancy plus the outstanding read must leave room.
        kredi_var     = ({1'b0, doluluk_q} + {{CW{1'b0}}, ucusta_q}) < KAPASITE;
        cek           = rst_n_g && !bb_buy_istek_g && kredi_var;
        yaz           = ucusta_q && !bb_buy_istek_g;
        oku           = gecerli && gc_hazir_g && !bb_buy_istek_g;
        gelen_buy     = istek_basbel_q ? basbel_douta_g : bb_douta_g;

        if (bb_buy_istek_g) begin
            getir_ps_d = bb_buy_istek_adres_g & ~ADRES_BIT'(3);
            yaz_ptr_d  = '0;
            oku_ptr_d  = '0;
            doluluk_d  = '0;
        end else begin
            if (cek) begin
                getir_ps_d     = getir_ps_q + ADRES_BIT'(4);
                ucusta_d       = 1'b1;
                istek_ps_d     = getir_ps_q;
                istek_basbel_d = kaynak_basbel;
            end
            if (yaz) begin
                buy_mem_d[yaz_ptr_q] = gelen_buy;
                ps_mem_d[yaz_ptr_q]  = istek_ps_q;
                yaz_ptr_d            = yaz_ptr_q + PW'(1);
            end
            if (oku) begin
                oku_ptr_d = oku_ptr_q + PW'(1);
            end
            case ({yaz, oku})
                2'b10:   doluluk_d = doluluk_q + CW'(1);
                2'b01:   doluluk_d = doluluk_q - CW'(1);
                default: doluluk_d = doluluk_q;
            endcase
        end
    end

    always_ff @(posedge clk_g or negedge rst_n_g) begin
        if (!rst_n_g) begin
            getir_ps_q     <= BASLANGIC_ADRESI;
            ucusta_q       <= 1'b0;
            istek_ps_q     <= '0;
            istek_basbel_q <= 1'b0;
            yaz_ptr_q      <= '0;
            oku_ptr_q      <= '0;
            doluluk_q      <= '0;
            buy_mem_q      <= '{default: '0};
            ps_mem_q       <= '{default: '0};
        end else begin
            getir_ps_q     <= getir_ps_d;
            ucusta_q       <= ucusta_d;
            istek_ps_q     <= istek_ps_d;
            istek_basbel_q <= istek_basbel_d;
            yaz_ptr_q      <= yaz_ptr_d;
            oku_ptr_q      <= oku_ptr_d;
            doluluk_q      <= doluluk_d;
            buy_mem_q      <= buy_mem_d;
            ps_mem_q       <= ps_mem_d;
        end
    end

    assign bb_buy_gecerli_c = gecerli;
    assign bb_buy_c         = buy_mem_q[oku_ptr_q];
    assign bb_buy_ps_c      = ps_mem_q[oku_ptr_q];
    assign bb_ena_c         = cek && !kaynak_basbel;
    assign basbel_ena_c     = cek && kaynak_basbel;
    assign bb_addra_c       = getir_ps_q - BB_TABAN_ADR;
    assign basbel_addra_c   = getir_ps_q - BASBEL_TABAN_ADR;
    assign tampon_doluluk_c = doluluk_q;

`ifdef ON_TARAF_SAYAC_EN
    logic [31:0] yonlendirme_sayisi_q, yonlendirme_sayisi_d;
    logic [31:0] bos_bekleme_sayisi_q, bos_bekleme_sayisi_d;

    always_comb begin
        yonlendirme_sayisi_d = yonlendirme_sayisi_q;
        bos_bekleme_sayisi_d = bos_bekleme_sayisi_q;
        if (bb_buy_istek_g && (yonlendirme_sayisi_q != 32'hFFFF_FFFF)) begin
            yonlendirme_sayisi_d = yonlendirme_sayisi_q + 32'd1;
        end
        if (!gecerli && (bos_bekleme_sayisi_q != 32'hFFFF_FFFF)) begin
            bos_bekleme_sayisi_d = bos_bekleme_sayisi_q + 32'd1;
        end
    end

    always_ff @(posedge clk_g or negedge rst_n_g) begin
        if (!rst_n_g) begin
            yonlendirme_sayisi_q <= '0;
            bos_bekleme_sayisi_q <= '0;
        end else begin
            yonlendirme_sayisi_q <= yonlendirme_sayisi_d;
            bos_bekleme_sayisi_q <= bos_bekleme_sayisi_d;
        end
    end

    assign yonlendirme_sayisi_c = yonlendirme_sayisi_q;
    assign bos_bekleme_sayisi_c = bos_bekleme_sayisi_q;
`endif

endmodule

// File: tb/tb_on_taraf_tampon.sv
// tb/tb_on_taraf_tampon.sv - scoreboard bench for on_taraf_tampon.
module tb_on_taraf_tampon;

    logic        clk_g = 1'b0;
    logic        rst_n_g;
    logic        gc_hazir_g;
    logic        bb_buy_gecerli_c;
    logic [31:0] bb_buy_c;
    logic [31:0] bb_buy_ps_c;
    logic        bb_buy_istek_g;
    logic [31:0] bb_buy_istek_adres_g;
    logic [31:0] bb_addra_c;
    logic        bb_ena_c;
    logic [31:0] bb_douta_g = '0;
    logic [31:0] basbel_addra_c;
    logic        basbel_ena_c;
    logic [31:0] basbel_douta_g = '0;
    logic [2:0]  tampon_doluluk_c;
`ifdef ON_TARAF_SAYAC_EN
    logic [31:0] yonlendirme_sayisi_c;
    logic [31:0] bos_bekleme_sayisi_c;
`endif

    on_taraf_tampon dut (
        .clk_g(clk_g), .rst_n_g(rst_n_g), .gc_hazir_g(gc_hazir_g),
        .bb_buy_gecerli_c(bb_buy_gecerli_c), .bb_buy_c(bb_buy_c), .bb_buy_ps_c(bb_buy_ps_c),
        .bb_buy_istek_g(bb_buy_istek_g), .bb_buy_istek_adres_g(bb_buy_istek_adres_g),
        .bb_addra_c(bb_addra_c), .bb_ena_c(bb_ena_c), .bb_douta_g(bb_douta_g),
        .basbel_addra_c(basbel_addra_c), .basbel_ena_c(basbel_ena_c),
        .basbel_douta_g(basbel_douta_g), .tampon_doluluk_c(tampon_doluluk_c)
`ifdef ON_TARAF_SAYAC_EN
        , .yonlendirme_sayisi_c(yonlendirme_sayisi_c), .bos_bekleme_sayisi_c(bos_bekleme_sayisi_c)
`endif
    );

    always #5 clk_g = ~clk_g;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pop  = 0;
    int n_redir = 0;
    logic [31:0] gen_pc;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_buy_q[$];

    function automatic logic [31:0] boot_word(input logic [31:0] off);
        if (off == 32'd0) return 32'h0000_0013;
        if (off == 32'd4) return 32'h0010_0093;
        return {8'hB0, off[23:0]};
    endfunction

    function automatic logic [31:0] inst_word(input logic [31:0] off);
        return {8'hC1, off[23:0]};
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        if (pc < 32'h4000_1000) return boot_word(pc - 32'h4000_0000);
        return inst_word(pc - 32'h4000_1000);
    endfunction

    // Memories answer one cycle after a read enable.
    always @(posedge clk_g) begin
        if (basbel_ena_c) basbel_douta_g <= boot_word(basbel_addra_c);
        if (bb_ena_c)     bb_douta_g     <= inst_word(bb_addra_c);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flush_exp();
        exp_pc_q.delete();
        exp_buy_q.delete();
    endtask

    task automatic topup();
        while (exp_pc_q.size() < 8) begin
            exp_pc_q.push_back(gen_pc);
            exp_buy_q.push_back(word_at(gen_pc));
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk_g);
        #1;
        topup();
    endtask

    task automatic redirect_start(input logic [31:0] a);
        bb_buy_istek_g       = 1'b1;
        bb_buy_istek_adres_g = a;
        n_redir++;
        flush_exp();
        gen_pc = {a[31:2], 2'b00};
        topup();
    endtask

    always @(negedge clk_g) begin
        if (rst_n_g && bb_buy_gecerli_c && gc_hazir_g && !bb_buy_istek_g) begin
            n_pop++;
            if (exp_pc_q.size() == 0) begin
                chk("unexpected_pop", bb_buy_ps_c, 32'hFFFF_FFFF);
            end else begin
                chk("head_pc", bb_buy_ps_c, exp_pc_q.pop_front());
                chk("head_word", bb_buy_c, exp_buy_q.pop_front());
            end
        end
    end

    initial begin
        int k;
        int p0;
        rst_n_g = 1'b0; gc_hazir_g = 1'b1;
        bb_buy_istek_g = 1'b0; bb_buy_istek_adres_g = '0;
        gen_pc = 32'h4000_0000;
        repeat (3) @(posedge clk_g);
        #1;
        chk("rst_valid", 32'(bb_buy_gecerli_c), 32'd0);
        chk("rst_bb_ena", 32'(bb_ena_c), 32'd0);
        chk("rst_basbel_ena", 32'(basbel_ena_c), 32'd0);
        chk("rst_occ", 32'(tampon_doluluk_c), 32'd0);
        chk("rst_word", bb_buy_c, 32'd0);

        rst_n_g = 1'b1; flush_exp(); gen_pc = 32'h4000_0000; topup();
        #1;
        chk("c0_basbel_ena", 32'(basbel_ena_c), 32'd1);
        chk("c0_bb_ena", 32'(bb_ena_c), 32'd0);
        chk("c0_basbel_addr", basbel_addra_c, 32'd0);
        tick(); #1;
        chk("c1_valid", 32'(bb_buy_gecerli_c), 32'd0);
        tick(); #1;
        chk("c2_valid", 32'(bb_buy_gecerli_c), 32'd1);
        chk("c2_word", bb_buy_c, 32'h0000_0013);
        chk("c2_pc", bb_buy_ps_c, 32'h4000_0000);
`ifdef ON_TARAF_SAYAC_EN
        chk("empty_cnt_ge2", 32'(bos_bekleme_sayisi_c >= 32'd2), 32'd1);
`endif
        tick(); #1;
        chk("c3_pc", bb_buy_ps_c, 32'h4000_0004);

        gc_hazir_g = 1'b0;
        repeat (10) tick();
        #1;
        chk("full_occ", 32'(tampon_doluluk_c), 32'd4);
        chk("full_no_ena", 32'(bb_ena_c | basbel_ena_c), 32'd0);
        gc_hazir_g = 1'b1; #1;
        chk("pop_cycle_no_ena", 32'(bb_ena_c | basbel_ena_c), 32'd0);
        tick(); #1;
        chk("credit_ena", 32'(bb_ena_c | basbel_ena_c), 32'd1);

        tick(); gc_hazir_g = 1'b0;
        k = 0;
        while (tampon_doluluk_c != 3'd3 && k < 10) begin
            tick(); k++;
        end
        chk("fill_to_3", 32'(tampon_doluluk_c), 32'd3);
        redirect_start(32'h4000_1007); #1;
        chk("redir_no_ena", 32'(bb_ena_c | basbel_ena_c), 32'd0);
        tick(); bb_buy_istek_g = 1'b0; #1;
        chk("redir_occ0", 32'(tampon_doluluk_c), 32'd0);
        chk("redir_bb_ena", 32'(bb_ena_c), 32'd1);
        chk("redir_bb_addr", bb_addra_c, 32'd4);
        chk("redir_basbel_off", 32'(basbel_ena_c), 32'd0);
        tick(); #1;
        chk("redir_t2_valid", 32'(bb_buy_gecerli_c), 32'd0);
        tick(); #1;
        chk("redir_t3_valid", 32'(bb_buy_gecerli_c), 32'd1);
        chk("redir_t3_pc", bb_buy_ps_c, 32'h4000_1004);
        chk("redir_t3_word", bb_buy_c, inst_word(32'h4));

        gc_hazir_g = 1'b1;
        redirect_start(32'h4000_0FF0);
        tick(); bb_buy_istek_g = 1'b0; #1;
        chk("cross_ena_ff0", 32'(basbel_ena_c), 32'd1);
        chk("cross_addr_ff0", basbel_addra_c, 32'h0000_0FF0);
        for (int a = 32'hFF4; a <= 32'hFFC; a += 4) begin
            tick(); #1;
            chk("cross_ena", 32'(basbel_ena_c), 32'd1);
            chk("cross_addr", basbel_addra_c, 32'(a));
        end
        tick(); #1;
        chk("cross_bb_ena", 32'(bb_ena_c), 32'd1);
        chk("cross_basbel_off", 32'(basbel_ena_c), 32'd0);
        chk("cross_bb_addr", bb_addra_c, 32'd0);

        p0 = n_pop;
        repeat (16) tick();
        chk("throughput", 32'(n_pop - p0), 32'd16);

        gc_hazir_g = 1'b0;
        repeat (3) tick();
        chk("pre_reset_nonempty", 32'(tampon_doluluk_c != 3'd0), 32'd1);
        #2;
        rst_n_g = 1'b0; flush_exp(); n_redir = 0;
        #1;
        chk("async_valid", 32'(bb_buy_gecerli_c), 32'd0);
        chk("async_occ", 32'(tampon_doluluk_c), 32'd0);
        chk("async_ena", 32'(bb_ena_c | basbel_ena_c), 32'd0);
        chk("async_word", bb_buy_c, 32'd0);
        repeat (2) @(posedge clk_g);
        #1;
        rst_n_g = 1'b1; gen_pc = 32'h4000_0000; topup(); gc_hazir_g = 1'b1;
        #1;
        chk("restart_ena", 32'(basbel_ena_c), 32'd1);
        chk("restart_addr", basbel_addra_c, 32'd0);

        gc_hazir_g = 1'b0;
        redirect_start(32'h4000_1100);
        tick(); redirect_start(32'h4000_0F40);
        tick(); bb_buy_istek_g = 1'b0;
        tick(); tick(); #1;
        chk("b2b_valid", 32'(bb_buy_gecerli_c), 32'd1);
        chk("b2b_pc", bb_buy_ps_c, 32'h4000_0F40);

        repeat (1500) begin
            tick();
            gc_hazir_g = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_start(($urandom_range(0, 1) ? 32'h4000_0F00 : 32'h4000_1000)
                               + 32'($urandom_range(0, 255)));
            end else begin
                bb_buy_istek_g = 1'b0;
            end
        end
        tick(); bb_buy_istek_g = 1'b0; gc_hazir_g = 1'b1;
        repeat (5) tick();
`ifdef ON_TARAF_SAYAC_EN
        chk("redirect_count", yonlendirme_sayisi_c, 32'(n_redir));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/on_taraf_tampon.md
Name: on_taraf_tampon

Overview:
- Parametrised successor to the single-register fetch front end.
- Sits between the instruction memories (boot memory and instruction memory) and the C0 decode stage (GC).
- Issues pipelined reads from its own fetch counter into a DERINLIK-entry prefetch FIFO, tracking outstanding reads with credits, and holds each instruction with its PC until GC consumes it.
- On a redirect it flushes the FIFO, discards any in-flight response and restarts fetch at the requested address.

Parameters:
- ADRES_BIT, 32, width of all addresses and PCs.
- BUYRUK_BIT, 32, instruction width; must equal memory data width.
- DERINLIK, 4, FIFO entries; power of two, >= 2.
- BASLANGIC_ADRESI, 32'h4000_0000, fetch PC after reset.
- BASBEL_TABAN_ADR, 32'h4000_0000, boot memory base.
- BB_TABAN_ADR, 32'h4000_1000, instruction memory base; addresses below it read boot memory.

Ports:
- clk_g  in  1  clock
- rst_n_g  in  1  asynchronous active-low reset
- gc_hazir_g  in  1  GC accepts the head instruction this cycle
- bb_buy_gecerli_c  out  1  head instruction valid
- bb_buy_c  out  BUYRUK_BIT  head instruction
- bb_buy_ps_c  out  ADRES_BIT  PC of head instruction
- bb_buy_istek_g  in  1  redirect request
- bb_buy_istek_adres_g  in  ADRES_BIT  redirect target
- bb_addra_c  out  ADRES_BIT  instruction memory address (PC - BB_TABAN_ADR)
- bb_ena_c  out  1  instruction memory read enable
- bb_douta_g  in  BUYRUK_BIT  instruction memory data, 1 cycle after enable
- basbel_addra_c  out  ADRES_BIT  boot memory address (PC - BASBEL_TABAN_ADR)
- basbel_ena_c  out  1  boot memory read enable
- basbel_douta_g  in  BUYRUK_BIT  boot memory data, 1 cycle after enable
- tampon_doluluk_c  out  $clog2(DERINLIK)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - getir_ps = BASLANGIC_ADRESI; FIFO empty; in-flight flag 0.
  - All outputs 0: bb_buy_gecerli_c=0, bb_ena_c=0, basbel_ena_c=0, tampon_doluluk_c=0.
- Issue condition: no redirect this cycle AND occupancy + inflight < DERINLIK.
  - occupancy is the registered value; a pop in the same cycle does not add credit.
- On issue:
  - Exactly one of bb_ena_c / basbel_ena_c is high: basbel_ena_c if getir_ps < BB_TABAN_ADR, else bb_ena_c.
  - getir_ps += 4, wrapping modulo 2^ADRES_BIT.
  - inflight <= 1; the issuing PC and the source select are registered.
  - Both address outputs are always driven combinationally from getir_ps.
- Response, cycle after an issue:
  - Data comes from the registered source (basbel_douta_g or bb_douta_g).
  - Data and PC are written to the FIFO tail unless a redirect occurs in that same cycle; then the response is dropped.
  - inflight clears unless a new issue occurs.
- Head:
  - bb_buy_gecerli_c = !empty; bb_buy_c / bb_buy_ps_c are the registered head entry.
  - Pop occurs when valid && gc_hazir_g && !bb_buy_istek_g.
  - Pop and push in the same cycle: occupancy unchanged; pointers wrap modulo DERINLIK.
- Redirect (bb_buy_istek_g=1), highest priority:
  - Same edge: FIFO flushed (occupancy 0), inflight cleared, getir_ps <= {bb_buy_istek_adres_g[ADRES_BIT-1:2], 2'b00}.
  - No memory enable in the redirect cycle; any pop request is ignored.
  - Timing: issue at T+1, push at T+2, bb_buy_gecerli_c=1 at T+3. Same timing after reset release (first valid at cycle 2).
- Back-to-back redirects: only the last target is fetched.
- Throughput: with DERINLIK>=2 and gc_hazir_g held high, one instruction per cycle in steady state.
- Full FIFO: no issue. Issue resumes the cycle after a pop frees a credit.

Optional Feature:
- ON_TARAF_SAYAC_EN: adds 32-bit outputs yonlendirme_sayisi_c (redirect count) and bos_bekleme_sayisi_c (cycles with FIFO empty and not in reset).
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Without the macro, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Reset release, gc_hazir_g=1, boot words 0x00000013,0x00100093 at BASBEL offsets 0,4:
  - basbel_ena_c=1 at cycle 0 with basbel_addra_c=0.
  - bb_buy_gecerli_c=1 at cycle 2 with bb_buy_c=0x00000013, bb_buy_ps_c=0x40000000.
  - Next cycle bb_buy_ps_c=0x40000004.
- gc_hazir_g=0 for 10 cycles:
  - tampon_doluluk_c reaches 4, then no enables.
  - Release: instructions in PC order 0x40000000..0x4000000C, no loss or duplication.
- bb_buy_istek_g=1 with address 0x40001007 while FIFO holds 3 entries and a read is in flight:
  - Occupancy 0 next cycle; bb_ena_c=1 with bb_addra_c=0x4, then valid 3 cycles after the request.
  - bb_buy_ps_c=0x40001004; the old in-flight data never appears.
- Sequential fetch crossing 0x40000FFC -> 0x40001000: source switches from basbel_ena_c to bb_ena_c with bb_addra_c=0.
- rst_n_g asserted mid-stream with FIFO non-empty: outputs 0 immediately (asynchronous); after release, fetch restarts at BASLANGIC_ADRESI.
- With ON_TARAF_SAYAC_EN: two redirects -> yonlendirme_sayisi_c=2; first 2 cycles after reset -> bos_bekleme_sayisi_c>=2.
